// File: rtl/inst_trace_fifo.sv
// inst_trace_fifo
// ---------------
// Debug companion for the MIPS core. It has two jobs:
//   1. Live display. Each pipeline stage's instruction word is decoded into a
//      right-justified, NUL-padded ASCII mnemonic. The result is registered so
//      that it lines up one cycle behind the stage inputs in a waveform viewer.
//   2. Retirement trace. Each committed instruction is stored as
//      {pc, word, mnemonic} in a DEPTH-entry buffer. A debug reader drains
//      that buffer through a show-ahead valid/ready port.
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   stage_instr       STAGES x 32-bit instruction words (stage i at [32i+:32])
//   stage_valid       per-stage "holds a real instruction" (0 = bubble)
//   stage_ascii       STAGES x NAME_W registered mnemonics ("-" for bubbles)
//   commit_valid/pc/instr  retiring instruction from the commit point
//   freeze            while 1, commits are ignored; reads keep working
//   clr_ovf           synchronous clear of the sticky overflow flag
//   rd_valid/rd_ready/rd_pc/rd_instr/rd_ascii  trace read port
//   count             number of entries held (0..DEPTH)
//   overflow          sticky: a commit was dropped or an entry was overwritten
//
// Read handshake: rd_valid is high whenever the buffer holds an entry, and
// rd_pc/rd_instr/rd_ascii then present the head entry. A transfer (pop) takes
// place on a rising edge where rd_valid && rd_ready. rd_ready with rd_valid
// low has no effect. rd_valid does not depend on rd_ready.
//
// The block has no back-pressure toward the pipeline. When the buffer is full,
// MODE 0 drops the newest commit and MODE 1 overwrites the oldest entry.

module inst_trace_fifo #(
  parameter int STAGES = 5,
  parameter int DEPTH  = 16,
  parameter int NAME_W = 48,
  parameter int MODE   = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [32*STAGES-1:0]       stage_instr,
  input  logic [STAGES-1:0]          stage_valid,
  output logic [NAME_W*STAGES-1:0]   stage_ascii,
  input  logic                       commit_valid,
  input  logic [31:0]                commit_pc,
  input  logic [31:0]                commit_instr,
  input  logic                       freeze,
  input  logic                       clr_ovf,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [31:0]                rd_pc,
  output logic [31:0]                rd_instr,
  output logic [NAME_W-1:0]          rd_ascii,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam bit CIRC = (MODE == 1);

  // Shared decoder. The mnemonic is built in a 6-character field. The size
  // cast right-justifies it and fills the unused upper bytes with 0x00.
  function automatic logic [NAME_W-1:0] decode(input logic [31:0] w);
    logic [47:0] m;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  rs;
    logic [4:0]  rt;
    op = w[31:26];
    rs = w[25:21];
    rt = w[20:16];
    fn = w[5:0];
    m  = 48'("N-R");
    if (w == 32'h0000_0000) begin
      m = 48'("NOP");
    end else if (w == 32'h4200_0018) begin
      m = 48'("ERET");
    end else begin
      case (op)
        6'h00: begin
          case (fn)
            6'h00: m = 48'("SLL");
            6'h02: m = 48'("SRL");
            6'h03: m = 48'("SRA");
            6'h04: m = 48'("SLLV");
            6'h06: m = 48'("SRLV");
            6'h07: m = 48'("SRAV");
            6'h08: m = 48'("JR");
            6'h09: m = 48'("JALR");
            6'h0C: m = 48'("SYSC");
            6'h0D: m = 48'("BRE");
            6'h10: m = 48'("MFHI");
            6'h11: m = 48'("MTHI");
            6'h12: m = 48'("MFLO");
            6'h13: m = 48'("MTLO");
            6'h18: m = 48'("MULT");
            6'h19: m = 48'("MULTU");
            6'h1A: m = 48'("DIV");
            6'h1B: m = 48'("DIVU");
            6'h20: m = 48'("ADD");
            6'h21: m = 48'("ADDU");
            6'h22: m = 48'("SUB");
            6'h23: m = 48'("SUBU");
            6'h24: m = 48'("AND");
            6'h25: m = 48'("OR");
            6'h26: m = 48'("XOR");
            6'h27: m = 48'("NOR");
            6'h2A: m = 48'("SLT");
            6'h2B: m = 48'("SLTU");
            default: m = 48'("N-R");
          endcase
        end
        6'h01: begin
          case (rt)
            5'h00: m = 48'("BLTZ");
            5'h01: m = 48'("BGEZ");
            5'h10: m = 48'("BLTZAL");
            5'h11: m = 48'("BGEZAL");
            default: m = 48'("N-R");
          endcase
        end
        6'h10: begin
          case (rs)
            5'h04: m = 48'("MTC0");
            5'h00: m = 48'("MFC0");
            default: m = 48'("N-R");
          endcase
        end
        6'h02: m = 48'("J");
        6'h03: m = 48'("JAL");
        6'h04: m = 48'("BEQ");
        6'h05: m = 48'("BNE");
        6'h06: m = 48'("BLEZ");
        6'h07: m = 48'("BGTZ");
        6'h08: m = 48'("ADDI");
        6'h09: m = 48'("ADDIU");
        6'h0A: m = 48'("SLTI");
        6'h0B: m = 48'("SLTIU");
        6'h0C: m = 48'("ANDI");
        6'h0D: m = 48'("ORI");
        6'h0E: m = 48'("XORI");
        6'h0F: m = 48'("LUI");
        6'h20: m = 48'("LB");
        6'h21: m = 48'("LH");
        6'h23: m = 48'("LW");
        6'h24: m = 48'("LBU");
        6'h25: m = 48'("LHU");
        6'h28: m = 48'("SB");
        6'h29: m = 48'("SH");
        6'h2B: m = 48'("SW");
        default: m = 48'("N-R");
      endcase
    end
    return NAME_W'(m);
  endfunction

  // ---------------------------------------------------------------- display
  logic [NAME_W*STAGES-1:0] stage_ascii_q;
  logic [NAME_W*STAGES-1:0] stage_ascii_d;

  always_comb begin
    stage_ascii_d = '0;
    for (int i = 0; i < STAGES; i++) begin
      stage_ascii_d[i*NAME_W +: NAME_W] = stage_valid[i] ?
        decode(stage_instr[i*32 +: 32]) : NAME_W'(8'h2D);  // "-"
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stage_ascii_q <= '0;
    else     stage_ascii_q <= stage_ascii_d;
  end

  assign stage_ascii = stage_ascii_q;

  // ------------------------------------------------------------ trace buffer
  logic [31:0]       mem_pc    [DEPTH];
  logic [31:0]       mem_instr [DEPTH];
  logic [NAME_W-1:0] mem_ascii [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;

  logic push_req, push, pop, full, drop, overwrite;

  always_comb begin
    push_req = commit_valid && !freeze;
    pop      = (count_q != '0) && rd_ready;
    full     = (count_q == CW'(DEPTH));
    // When a pop happens in the same cycle, a full buffer still has room
    // for the new entry, so neither mode loses data in that case.
    if (CIRC) begin
      push      = push_req;
      overwrite = push_req && full && !pop;
      drop      = 1'b0;
    end else begin
      push      = push_req && (!full || pop);
      overwrite = 1'b0;
      drop      = push_req && full && !pop;
    end

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    // An overwrite moves the head past the entry being replaced.
    rd_ptr_d = (pop || overwrite) ? rd_ptr_q + 1'b1 : rd_ptr_q;

    count_d = count_q;
    if (push && !pop && !overwrite) count_d = count_q + 1'b1;
    else if (pop && !push)          count_d = count_q - 1'b1;

    overflow_d = overflow_q;
    if (drop || overwrite) overflow_d = 1'b1;
    else if (clr_ovf)      overflow_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is not reset. Empty slots are never presented because the read
  // outputs are gated by rd_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr_q]    <= commit_pc;
      mem_instr[wr_ptr_q] <= commit_instr;
      mem_ascii[wr_ptr_q] <= decode(commit_instr);
    end
  end

  assign rd_valid = (count_q != '0);
  assign rd_pc    = rd_valid ? mem_pc[rd_ptr_q]    : '0;
  assign rd_instr = rd_valid ? mem_instr[rd_ptr_q] : '0;
  assign rd_ascii = rd_valid ? mem_ascii[rd_ptr_q] : '0;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_inst_trace_fifo.sv
module tb_inst_trace_fifo;

  localparam int STAGES = 5;
  localparam int DEPTH  = 4;
  localparam int NAME_W = 48;
  localparam int CW     = $clog2(DEPTH) + 1;

  // ---------------------------------------------------------- clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [32*STAGES-1:0] stage_instr;
  logic [STAGES-1:0]    stage_valid;
  logic                 commit_valid;
  logic [31:0]          commit_pc;
  logic [31:0]          commit_instr;
  logic                 freeze;
  logic                 clr_ovf;
  logic                 rd_ready;

  // dut0: stop-on-full, dut1: circular; both see identical stimulus
  logic [NAME_W*STAGES-1:0] s_ascii0, s_ascii1;
  logic                     rd_valid0, rd_valid1;
  logic [31:0]              rd_pc0, rd_pc1, rd_instr0, rd_instr1;
  logic [NAME_W-1:0]        rd_ascii0, rd_ascii1;
  logic [CW-1:0]            count0, count1;
  logic                     ovf0, ovf1;

  inst_trace_fifo #(.STAGES(STAGES), .DEPTH(DEPTH), .NAME_W(NAME_W), .MODE(0)) dut0 (
    .clk(clk), .rst(rst), .stage_instr(stage_instr), .stage_valid(stage_valid),
    .stage_ascii(s_ascii0), .commit_valid(commit_valid), .commit_pc(commit_pc),
    .commit_instr(commit_instr), .freeze(freeze), .clr_ovf(clr_ovf),
    .rd_valid(rd_valid0), .rd_ready(rd_ready), .rd_pc(rd_pc0), .rd_instr(rd_instr0),
    .rd_ascii(rd_ascii0), .count(count0), .overflow(ovf0)
  );

  inst_trace_fifo #(.STAGES(STAGES), .DEPTH(DEPTH), .NAME_W(NAME_W), .MODE(1)) dut1 (
    .clk(clk), .rst(rst), .stage_instr(stage_instr), .stage_valid(stage_valid),
    .stage_ascii(s_ascii1), .commit_valid(commit_valid), .commit_pc(commit_pc),
    .commit_instr(commit_instr), .freeze(freeze), .clr_ovf(clr_ovf),
    .rd_valid(rd_valid1), .rd_ready(rd_ready), .rd_pc(rd_pc1), .rd_instr(rd_instr1),
    .rd_ascii(rd_ascii1), .count(count1), .overflow(ovf1)
  );

  // ------------------------------------------------------------- scoreboard
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs checked then too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_both_count(input string name, input int c, input logic ov);
    chk({name, " count0"}, 64'(count0), 64'(c));
    chk({name, " count1"}, 64'(count1), 64'(c));
    chk({name, " ovf0"}, 64'(ovf0), 64'(ov));
    chk({name, " ovf1"}, 64'(ovf1), 64'(ov));
  endtask

  // -------------------------------------------------------- decode vectors
  typedef struct {
    logic [31:0] word;
    logic [47:0] exp;
  } dec_vec_t;

  dec_vec_t dec_tab[18];

  localparam logic [31:0] LW_WORD = 32'h8C08_0000;

  initial begin
    dec_tab[0]  = '{32'h0000_0000, 48'("NOP")};
    dec_tab[1]  = '{32'h4200_0018, 48'("ERET")};
    dec_tab[2]  = '{32'h0411_0000, 48'("BGEZAL")};
    dec_tab[3]  = '{32'h0410_0000, 48'("BLTZAL")};
    dec_tab[4]  = '{32'h0401_0000, 48'("BGEZ")};
    dec_tab[5]  = '{32'h0400_0004, 48'("BLTZ")};
    dec_tab[6]  = '{32'h0403_0000, 48'("N-R")};
    dec_tab[7]  = '{32'h0000_0019, 48'("MULTU")};
    dec_tab[8]  = '{32'h0043_0820, 48'("ADD")};
    dec_tab[9]  = '{32'h03E0_0008, 48'("JR")};
    dec_tab[10] = '{32'h0000_003F, 48'("N-R")};
    dec_tab[11] = '{32'h4000_6000, 48'("MFC0")};
    dec_tab[12] = '{32'h40A0_6000, 48'("N-R")};
    dec_tab[13] = '{32'h3C01_0000, 48'("LUI")};
    dec_tab[14] = '{LW_WORD,       48'("LW")};
    dec_tab[15] = '{32'hAC00_0000, 48'("SW")};
    dec_tab[16] = '{32'h0000_000C, 48'("SYSC")};
    dec_tab[17] = '{32'h0C00_0000, 48'("JAL")};
  end

  // --------------------------------------------------------------- stimulus
  initial begin
    rst = 1'b1;
    stage_instr = '0; stage_valid = '0;
    commit_valid = 1'b0; commit_pc = '0; commit_instr = '0;
    freeze = 1'b0; clr_ovf = 1'b0; rd_ready = 1'b0;

    tick(); tick();
    chk("reset rd_valid0", 64'(rd_valid0), 64'd0);
    chk("reset rd_valid1", 64'(rd_valid1), 64'd0);
    chk("reset rd_pc0", 64'(rd_pc0), 64'd0);
    chk("reset stage_ascii0", 64'(s_ascii0[63:0]), 64'd0);
    chk_both_count("reset", 0, 1'b0);
    rst = 1'b0;

    // Decode table, same word in every stage
    stage_valid = '1;
    for (int i = 0; i < 18; i++) begin
      stage_instr = {STAGES{dec_tab[i].word}};
      tick();
      for (int s = 0; s < STAGES; s++)
        chk($sformatf("decode[%0d] stage%0d", i, s),
            64'(s_ascii0[s*NAME_W +: NAME_W]), 64'(dec_tab[i].exp));
    end

    // Distinct word per stage, then a bubble in stage 2
    stage_instr = {32'hFC00_0000, 32'h4080_6000, 32'h4200_0018, 32'h0411_0000, 32'h0000_0000};
    tick();
    chk("pattern s0", 64'(s_ascii0[0*NAME_W +: NAME_W]), 64'(48'("NOP")));
    chk("pattern s1", 64'(s_ascii0[1*NAME_W +: NAME_W]), 64'(48'("BGEZAL")));
    chk("pattern s2", 64'(s_ascii0[2*NAME_W +: NAME_W]), 64'(48'("ERET")));
    chk("pattern s3", 64'(s_ascii0[3*NAME_W +: NAME_W]), 64'(48'("MTC0")));
    chk("pattern s4", 64'(s_ascii1[4*NAME_W +: NAME_W]), 64'(48'("N-R")));
    stage_valid = 5'b11011;
    tick();
    chk("bubble s2", 64'(s_ascii0[2*NAME_W +: NAME_W]), 64'h2D);
    chk("bubble s3", 64'(s_ascii0[3*NAME_W +: NAME_W]), 64'(48'("MTC0")));

    // Overfill with 5 commits
    commit_instr = LW_WORD;
    commit_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      commit_pc = 32'h100 + 32'(4 * k);
      rd_ready = 1'b1;  // no effect: buffer empty on the first edge
      if (k > 0) rd_ready = 1'b0;
      tick();
      if (k == 0) begin
        chk("first commit count0", 64'(count0), 64'd1);
        chk("first commit rd_pc0", 64'(rd_pc0), 64'h100);
        chk("first commit rd_valid1", 64'(rd_valid1), 64'd1);
      end
    end
    commit_valid = 1'b0;
    chk_both_count("overfill", 4, 1'b1);

    rd_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drain%0d rd_pc0", k), 64'(rd_pc0), 64'(32'h100 + 32'(4 * k)));
      chk($sformatf("drain%0d rd_pc1", k), 64'(rd_pc1), 64'(32'h104 + 32'(4 * k)));
      chk($sformatf("drain%0d rd_ascii0", k), 64'(rd_ascii0), 64'(48'("LW")));
      chk($sformatf("drain%0d rd_instr1", k), 64'(rd_instr1), 64'(LW_WORD));
      tick();
    end
    rd_ready = 1'b0;
    chk("drained count0", 64'(count0), 64'd0);
    chk("drained count1", 64'(count1), 64'd0);
    chk("drained rd_pc0", 64'(rd_pc0), 64'd0);
    chk("drained rd_ascii1", 64'(rd_ascii1), 64'd0);
    chk("drained rd_valid0", 64'(rd_valid0), 64'd0);

    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk_both_count("clr_ovf", 0, 1'b0);

    // Full buffer with commit and pop in the same cycle
    commit_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      commit_pc = 32'h200 + 32'(4 * k);
      tick();
    end
    chk_both_count("refill", 4, 1'b0);
    commit_pc = 32'h210;
    rd_ready = 1'b1;
    chk("popped oldest pc0", 64'(rd_pc0), 64'h200);
    chk("popped oldest pc1", 64'(rd_pc1), 64'h200);
    tick();
    commit_valid = 1'b0;
    chk_both_count("full push+pop", 4, 1'b0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("after push+pop%0d pc0", k), 64'(rd_pc0), 64'(32'h204 + 32'(4 * k)));
      chk($sformatf("after push+pop%0d pc1", k), 64'(rd_pc1), 64'(32'h204 + 32'(4 * k)));
      tick();
    end
    rd_ready = 1'b0;
    chk_both_count("empty again", 0, 1'b0);

    // Freeze
    freeze = 1'b1;
    commit_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      commit_pc = 32'h300 + 32'(4 * k);
      tick();
    end
    chk_both_count("frozen", 0, 1'b0);
    freeze = 1'b0;
    commit_pc = 32'h30C;
    tick();
    commit_valid = 1'b0;
    chk_both_count("unfrozen", 1, 1'b0);
    chk("unfrozen rd_pc0", 64'(rd_pc0), 64'h30C);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;

    // Async reset with three entries held
    commit_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      commit_pc = 32'h400 + 32'(4 * k);
      tick();
    end
    commit_valid = 1'b0;
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    chk_both_count("pre-reset", 3, 1'b1);
    chk("pre-reset rd_pc1", 64'(rd_pc1), 64'h408);
    #3;
    rst = 1'b1;
    #1;
    chk("async rst rd_valid0", 64'(rd_valid0), 64'd0);
    chk("async rst rd_valid1", 64'(rd_valid1), 64'd0);
    chk("async rst rd_pc0", 64'(rd_pc0), 64'd0);
    chk_both_count("async rst", 0, 1'b0);
    #1;
    rst = 1'b0;
    tick();
    commit_valid = 1'b1;
    commit_pc = 32'h500;
    commit_instr = 32'h0000_0019;
    tick();
    commit_valid = 1'b0;
    chk("post-reset rd_pc0", 64'(rd_pc0), 64'h500);
    chk("post-reset rd_instr1", 64'(rd_instr1), 64'h19);
    chk("post-reset rd_ascii0", 64'(rd_ascii0), 64'(48'("MULTU")));
    chk("post-reset count1", 64'(count1), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_trace_fifo.md
# inst_trace_fifo

Parametrised debug block for the MIPS core. It decodes the instruction held in each of STAGES pipeline stages into registered fixed-width ASCII mnemonics for waveform viewing. It also records retired instructions (PC, word, mnemonic) into a DEPTH-entry trace buffer that a debug reader drains through a valid/ready handshake. It sits beside the datapath, is driven from the commit point, and never stalls the pipeline.

## Interface
- STAGES, 5, number of pipeline stages decoded for live display (1..8)
- DEPTH, 16, trace buffer entries; power of two, ≥2
- NAME_W, 48, mnemonic width in bits; multiple of 8, ≥48 (6 chars)
- MODE, 0, 0 = stop-on-full (drop newest), 1 = circular (overwrite oldest)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- stage_instr  in  32*STAGES  instruction word per stage, stage i at bits [32i+31:32i]
- stage_valid  in  STAGES  stage holds a real instruction (0 = bubble)
- stage_ascii  out  NAME_W*STAGES  registered mnemonic per stage
- commit_valid  in  1  an instruction retires this cycle
- commit_pc  in  32  PC of the retiring instruction
- commit_instr  in  32  word of the retiring instruction
- freeze  in  1  1 = ignore commits (trace held, e.g. after exception)
- clr_ovf  in  1  synchronous clear of overflow
- rd_valid  out  1  buffer non-empty; head entry presented
- rd_ready  in  1  reader consumes head when rd_valid=1
- rd_pc  out  32  head PC (0 when empty)
- rd_instr  out  32  head word (0 when empty)
- rd_ascii  out  NAME_W  head mnemonic (0 when empty)
- count  out  $clog2(DEPTH)+1  entries held
- overflow  out  1  sticky; set when any commit is dropped or any entry is overwritten

## Operation
- Decoder is a shared combinational function. Strings are right-justified, and unused upper bytes are 0x00. The full name is always preserved: "BGEZAL", "BLTZAL" and "MULTU" are never truncated.
- Decode priority:
  - word == 0 -> "NOP"
  - word == 0x42000018 -> "ERET"
  - opcode 0 -> funct table: AND OR XOR NOR SLL SRL SRA SLLV SRLV SRAV MFHI MTHI MFLO MTLO ADD ADDU SUB SUBU SLT SLTU MULT MULTU DIV DIVU JR JALR SYSC BRE
  - opcode 1 -> rt table: BGEZ BGEZAL BLTZ BLTZAL
  - opcode 0x10 -> rs=00100 "MTC0", rs=00000 "MFC0"
  - remaining opcodes: ANDI XORI LUI ORI ADDI ADDIU SLTI SLTIU J JAL BEQ BGTZ BLEZ BNE LB LBU LH LHU LW SB SH SW
  - anything unmatched, including unknown REGIMM rt and unknown COP0 rs -> "N-R"
- stage_ascii[i] <= stage_valid[i] ? decode(stage_instr[i]) : "-".
- Write: accepted when commit_valid && !freeze. The entry is {commit_pc, commit_instr, decode(commit_instr)}, written at wr_ptr.
- Read: pop when rd_valid && rd_ready. Outputs are show-ahead, read directly from storage at rd_ptr and gated to 0 when empty.
- Pointers are log2(DEPTH) bits and wrap naturally. count is tracked separately.
- Full, write, no pop:
  - MODE 0: write dropped, overflow <= 1.
  - MODE 1: write stored, rd_ptr advances, count stays DEPTH, overflow <= 1.
- Full, write and pop in the same cycle: both occur, count unchanged, no overflow, in both modes.
- Empty, write and rd_ready in the same cycle: no pop (rd_valid was 0), count becomes 1.
- Overflow: set has priority over clr_ovf in the same cycle.

## Timing
- Reset values (asynchronous): wr_ptr=rd_ptr=0, count=0, overflow=0, stage_ascii all 0. rd_* are therefore 0 and rd_valid=0.
- stage_ascii latency: 1 cycle after stage_instr/stage_valid.
- A commit in cycle N is visible on rd_valid/rd_* and count in cycle N+1. There is no same-cycle bypass.
- A pop in cycle N presents the next entry in cycle N+1.
- freeze is sampled per cycle with no latency. Reads continue while frozen.
- Reset asserted mid-operation discards all entries immediately. Storage contents need not be cleared.

## Test plan
- Decode sweep, STAGES=5, all valid, stages set to 0x00000000, 0x04110000, 0x42000018, 0x40806000, 0xFC000000 -> next cycle stage_ascii = "NOP", "BGEZAL", "ERET", "MTC0", "N-R". Then stage_valid[2]=0 -> "-" in stage 2.
- MODE 0, DEPTH=4, freeze=0, rd_ready=0: commit PCs 0x100,0x104,0x108,0x10C,0x110 with word 0x8C080000 -> count=4, overflow=1. Draining returns 0x100..0x10C, each with "LW". count reaches 0 and rd_pc=0 afterwards.
- MODE 1, same stimulus -> count=4, overflow=1, drain returns 0x104..0x110. Then clr_ovf -> overflow=0 next cycle.
- Full buffer with commit and pop in the same cycle (MODE 0) -> count stays 4, overflow stays 0, popped entry is the oldest, new entry is the last one read.
- freeze=1 with 3 commits -> count unchanged. freeze=0 with 1 commit -> count +1 the next cycle.
- rst pulsed asynchronously between clock edges with count=3 -> rd_valid=0, count=0, overflow=0 before the next edge. A subsequent commit reads back correctly.
